// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx
//   Serializes stereo PCM frames onto the WM8731 DAC data line in I2S format.
//   The codec is bus master: BCLK and DACLRCK arrive asynchronously and are
//   synchronized into the clk domain. Frames are buffered in a small FIFO fed by
//   a valid/ready handshake and fetched at every left-channel start.
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   enable                     1 = play FIFO contents, 0 = send silence without popping
//   sample_left/right/valid    frame input (two's complement words)
//   sample_ready               FIFO not full
//   fifo_level                 frames currently stored
//   aud_bclk, aud_daclrck      codec bit clock / word clock (0 = left, 1 = right)
//   aud_dacdat                 serial data, updated after each BCLK falling edge
//   underrun_count             saturating count of silent frames sent while enabled
module i2s_dac_tx #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [SAMPLE_WIDTH-1:0]       sample_left,
    input  logic [SAMPLE_WIDTH-1:0]       sample_right,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          aud_bclk,
    input  logic                          aud_daclrck,
    output logic                          aud_dacdat,
    output logic [15:0]                   underrun_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(SAMPLE_WIDTH);
    localparam int unsigned FW = 2 * SAMPLE_WIDTH;

    typedef enum logic [1:0] {StWaitFrame, StDelay, StShift, StPad} state_e;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic lrck_s1_q, lrck_s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_s3_q <= 1'b0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
        end else begin
            bclk_s1_q <= aud_bclk;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            lrck_s1_q <= aud_daclrck;
            lrck_s2_q <= lrck_s1_q;
        end
    end

    logic bclk_fall;
    logic lrck_prev_q;
    logic chan_start;
    logic left_start;

    assign bclk_fall  = bclk_s3_q & ~bclk_s2_q;
    assign chan_start = bclk_fall && (lrck_s2_q != lrck_prev_q);
    assign left_start = chan_start && !lrck_s2_q;

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [FW-1:0] rd_data;
    logic          fifo_empty, fifo_full;
    logic          push, pop, underrun;

    assign fifo_level   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty   = (fifo_level == '0);
    assign fifo_full    = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign sample_ready = !fifo_full;
    assign push         = sample_valid && sample_ready;
    // Pop is decided from registered state, so a push into an empty FIFO is
    // never forwarded to a same-cycle fetch.
    assign pop          = left_start && enable && !fifo_empty;
    assign underrun     = left_start && enable && fifo_empty;
    assign rd_data      = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {sample_left, sample_right};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_e                  state_q;
    logic [SAMPLE_WIDTH-1:0] word_q;
    logic [SAMPLE_WIDTH-1:0] right_hold_q;
    logic [CW-1:0]           bit_cnt_q;
    logic                    dacdat_q;

    assign aud_dacdat = dacdat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StWaitFrame;
            word_q       <= '0;
            right_hold_q <= '0;
            bit_cnt_q    <= '0;
            dacdat_q     <= 1'b0;
            lrck_prev_q  <= 1'b0;
        end else if (bclk_fall) begin
            lrck_prev_q <= lrck_s2_q;
            if (left_start) begin
                // Fetch a whole frame; the right word waits for the right start.
                state_q  <= StDelay;
                dacdat_q <= 1'b0;
                if (pop) begin
                    word_q       <= rd_data[FW-1:SAMPLE_WIDTH];
                    right_hold_q <= rd_data[SAMPLE_WIDTH-1:0];
                end else begin
                    word_q       <= '0;
                    right_hold_q <= '0;
                end
            end else if (chan_start && (state_q != StWaitFrame)) begin
                // Right start; also truncates a word still being shifted.
                state_q  <= StDelay;
                dacdat_q <= 1'b0;
                word_q   <= right_hold_q;
            end else begin
                case (state_q)
                    StDelay: begin
                        dacdat_q  <= word_q[SAMPLE_WIDTH-1];
                        bit_cnt_q <= CW'(SAMPLE_WIDTH - 1);
                        state_q   <= StShift;
                    end
                    StShift: begin
                        // bit_cnt_q is the index of the bit currently on the line.
                        if (bit_cnt_q == '0) begin
                            dacdat_q <= 1'b0;
                            state_q  <= StPad;
                        end else begin
                            dacdat_q  <= word_q[bit_cnt_q - CW'(1)];
                            bit_cnt_q <= bit_cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        dacdat_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
